// File: rtl/aes_pkg.sv
// Shared types and widths for the AES job arbiter slice: FSM states,
// AES block/word widths and the beat-index type.
package aes_pkg;

  localparam int AES_BLK_W     = 128;
  localparam int AES_WORD_W    = 32;
  localparam int AES_NUM_BEATS = AES_BLK_W / AES_WORD_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  typedef logic [$clog2(AES_NUM_BEATS)-1:0] beat_t;

endpackage

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester that did not
// win last time gets the grant. Purely combinational; the caller owns last_grant.
module aes_rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  // One-hot grant from the request vector and the previous winner
  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/aes_job_arbiter.sv
// Shares one AES input buffer/core between two requesters: round-robin grant,
// 128-bit job serialised into word beats, bounded wait for core_done, response.
module aes_job_arbiter
  import aes_pkg::*;
#(
  parameter int WORD_W         = AES_WORD_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [AES_BLK_W-1:0] req0_key,
  input  logic [AES_BLK_W-1:0] req0_text,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [AES_BLK_W-1:0] req1_key,
  input  logic [AES_BLK_W-1:0] req1_text,
  output logic                 buf_ld,
  output logic [WORD_W-1:0]    buf_key,
  output logic [WORD_W-1:0]    buf_text,
  input  logic                 core_done,
  input  logic [AES_BLK_W-1:0] core_result,
  output logic                 rsp0_valid,
  output logic                 rsp1_valid,
  input  logic                 rsp0_ready,
  input  logic                 rsp1_ready,
  output logic [AES_BLK_W-1:0] rsp_data,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam int NUM_BEATS = AES_BLK_W / WORD_W;
  localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                r_state;
  logic [BEAT_W-1:0]     r_beat;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_last_grant;
  logic                  r_gnt;
  logic [AES_BLK_W-1:0]  r_job_key;
  logic [AES_BLK_W-1:0]  r_job_text;
  logic                  r_buf_ld;
  logic [WORD_W-1:0]     r_buf_key;
  logic [WORD_W-1:0]     r_buf_text;
  logic                  r_rsp0_valid;
  logic                  r_rsp1_valid;
  logic [AES_BLK_W-1:0]  r_rsp_data;
  logic                  r_rsp_err;

  logic [1:0]            w_req;
  logic [1:0]            w_grant;
  logic [1:0]            w_accept;
  logic [AES_BLK_W-1:0]  w_sel_key;
  logic [AES_BLK_W-1:0]  w_sel_text;
  logic [BEAT_W-1:0]     w_next_beat;
  logic                  w_rsp_hs;

  assign w_req = {req1_valid, req0_valid};

  aes_rr_arb2 u_arb (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  // Ready is only offered from IDLE, and never while reset is being applied
  always_comb begin
    w_accept = 2'b00;
    if ((r_state == IDLE) && !rst) begin
      w_accept = w_grant;
    end else begin
      w_accept = 2'b00;
    end
  end

  assign req0_ready  = w_accept[0];
  assign req1_ready  = w_accept[1];
  assign w_sel_key   = w_accept[1] ? req1_key  : req0_key;
  assign w_sel_text  = w_accept[1] ? req1_text : req0_text;
  assign w_next_beat = r_beat + BEAT_W'(1);
  assign w_rsp_hs    = r_gnt ? rsp1_ready : rsp0_ready;

  assign buf_ld     = r_buf_ld;
  assign buf_key    = r_buf_key;
  assign buf_text   = r_buf_text;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_err    = r_rsp_err;
  assign busy       = (r_state != IDLE);

  // Job FSM; the buffer beat is pre-loaded one edge ahead so outputs stay registered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_beat       <= BEAT_W'(0);
      r_cnt        <= CNT_W'(0);
      r_last_grant <= 1'b1;
      r_gnt        <= 1'b0;
      r_job_key    <= AES_BLK_W'(0);
      r_job_text   <= AES_BLK_W'(0);
      r_buf_ld     <= 1'b0;
      r_buf_key    <= WORD_W'(0);
      r_buf_text   <= WORD_W'(0);
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp_data   <= AES_BLK_W'(0);
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept != 2'b00) begin
            r_gnt      <= w_accept[1];
            r_job_key  <= w_sel_key;
            r_job_text <= w_sel_text;
            r_beat     <= BEAT_W'(0);
            r_buf_ld   <= 1'b1;
            r_buf_key  <= w_sel_key[WORD_W-1:0];
            r_buf_text <= w_sel_text[WORD_W-1:0];
            r_state    <= LOAD;
          end
        end
        LOAD: begin
          r_buf_ld <= 1'b0;
          if (r_beat == LAST_BEAT) begin
            r_buf_key  <= WORD_W'(0);
            r_buf_text <= WORD_W'(0);
            r_cnt      <= CNT_W'(0);
            r_state    <= WAIT;
          end else begin
            r_beat     <= w_next_beat;
            r_buf_key  <= r_job_key[w_next_beat*WORD_W +: WORD_W];
            r_buf_text <= r_job_text[w_next_beat*WORD_W +: WORD_W];
          end
        end
        WAIT: begin
          // A done on the final timeout cycle still counts as success
          if (core_done) begin
            r_rsp_data   <= core_result;
            r_rsp_err    <= 1'b0;
            r_rsp0_valid <= ~r_gnt;
            r_rsp1_valid <= r_gnt;
            r_state      <= RESP;
          end else if (r_cnt == LAST_CNT) begin
            r_rsp_data   <= AES_BLK_W'(0);
            r_rsp_err    <= 1'b1;
            r_rsp0_valid <= ~r_gnt;
            r_rsp1_valid <= r_gnt;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (w_rsp_hs) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_data   <= AES_BLK_W'(0);
            r_cnt        <= CNT_W'(0);
            r_last_grant <= r_gnt;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Scoreboard bench for aes_job_arbiter: stimulus pushes expected beats and
// responses from a job-level model; a monitor pops and compares DUT outputs.
module tb_aes_job_arbiter;
  import aes_pkg::*;

  localparam int TO  = 64;
  localparam int TO8 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [127:0] req0_key, req0_text, req1_key, req1_text;
  logic         buf_ld;
  logic [31:0]  buf_key, buf_text;
  logic         core_done;
  logic [127:0] core_result;
  logic         rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [127:0] rsp_data;
  logic         rsp_err, busy;

  logic         t8_req0_valid, t8_req0_ready, t8_req1_ready;
  logic         t8_buf_ld, t8_rsp0_valid, t8_rsp1_valid, t8_rsp0_ready, t8_rsp_err, t8_busy;
  logic [31:0]  t8_buf_key, t8_buf_text;
  logic [127:0] t8_rsp_data;

  aes_job_arbiter #(.WORD_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_key(req0_key), .req0_text(req0_text),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_key(req1_key), .req1_text(req1_text),
    .buf_ld(buf_ld), .buf_key(buf_key), .buf_text(buf_text),
    .core_done(core_done), .core_result(core_result),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  aes_job_arbiter #(.WORD_W(32), .TIMEOUT_CYCLES(TO8)) dut8 (
    .clk(clk), .rst(rst),
    .req0_valid(t8_req0_valid), .req0_ready(t8_req0_ready), .req0_key(128'h1), .req0_text(128'h2),
    .req1_valid(1'b0), .req1_ready(t8_req1_ready), .req1_key(128'h0), .req1_text(128'h0),
    .buf_ld(t8_buf_ld), .buf_key(t8_buf_key), .buf_text(t8_buf_text),
    .core_done(1'b0), .core_result(128'h0),
    .rsp0_valid(t8_rsp0_valid), .rsp1_valid(t8_rsp1_valid), .rsp0_ready(t8_rsp0_ready), .rsp1_ready(1'b0),
    .rsp_data(t8_rsp_data), .rsp_err(t8_rsp_err), .busy(t8_busy)
  );

  typedef struct { int cyc; logic [127:0] key; logic [127:0] text; } beat_exp_t;
  typedef struct { bit who; logic [127:0] data; bit err; int cyc; } rsp_exp_t;

  beat_exp_t beat_q[$];
  rsp_exp_t  rsp_q[$];
  int  checks = 0, failures = 0;
  int  cyc = 0;
  int  ready_pulses = 0, exp_pulses = 0;
  bit  model_last = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Round-robin rule: on contention, the requester that did not win last
  function automatic bit rr_pick(input bit v0, input bit v1, input bit last);
    if (v0 && v1) return !last;
    else if (v1) return 1'b1;
    else return 1'b0;
  endfunction

  // Monitor: compares buffer beats and responses against queued expectations
  initial begin
    int        mon_beat;
    bit        rsp_active;
    beat_exp_t cur_b;
    rsp_exp_t  cur_r;
    mon_beat   = -1;
    rsp_active = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      chk("ready_onehot", req0_ready & req1_ready, 0);
      if (req0_ready || req1_ready) ready_pulses++;
      if (buf_ld) begin
        if (beat_q.size() == 0) chk("unexpected_ld", buf_ld, 0);
        else begin
          cur_b = beat_q.pop_front();
          chk("ld_cycle", cyc, cur_b.cyc);
          mon_beat = 0;
        end
      end
      if (mon_beat >= 0) begin
        chk("buf_ld", buf_ld, (mon_beat == 0));
        chk("buf_key", buf_key, cur_b.key[mon_beat*32 +: 32]);
        chk("buf_text", buf_text, cur_b.text[mon_beat*32 +: 32]);
        mon_beat++;
        if (mon_beat == 4) mon_beat = -1;
      end else begin
        chk("buf_idle", {buf_ld, buf_key, buf_text}, 0);
      end
      if (rsp0_valid || rsp1_valid) begin
        if (!rsp_active) begin
          if (rsp_q.size() == 0) chk("unexpected_rsp", {rsp1_valid, rsp0_valid}, 0);
          else begin
            cur_r = rsp_q.pop_front();
            rsp_active = 1'b1;
            chk("rsp_cycle", cyc, cur_r.cyc);
          end
        end
        if (rsp_active) begin
          chk("rsp_who", {rsp1_valid, rsp0_valid}, cur_r.who ? 2'b10 : 2'b01);
          chk("rsp_data", rsp_data, cur_r.data);
          chk("rsp_err", rsp_err, cur_r.err);
        end
      end else begin
        rsp_active = 1'b0;
        chk("rsp_err_idle", rsp_err, 0);
      end
    end
  end

  task automatic rand_keys();
    req0_key = rand128(); req0_text = rand128();
    req1_key = rand128(); req1_text = rand128();
  endtask

  // One job from request to response handshake; entered and left at a negedge
  task automatic run_job(input bit [1:0] vv, input int gap, input bit tmo, input int dly,
                         input bit spur, input int bp, input bit late, input logic [127:0] res);
    int start, t, d, r, n;
    bit w;
    beat_exp_t be;
    rsp_exp_t  re;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (gap) @(negedge clk);
    req0_valid = vv[0]; req1_valid = vv[1];
    start = cyc;
    n = 0;
    #1;
    while (!(req0_ready || req1_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("grant_wait", n, 0);
    if (n >= 20) begin
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    t = cyc;
    w = rr_pick(vv[0], vv[1], model_last);
    chk("grant_vec", {req1_ready, req0_ready}, w ? 2'b10 : 2'b01);
    chk("accept_cycle", t, start);
    exp_pulses++;
    be.cyc = t + 1; be.key = w ? req1_key : req0_key; be.text = w ? req1_text : req0_text;
    beat_q.push_back(be);
    d = t + 5 + dly;
    re.who = w;
    if (tmo) begin r = t + 5 + TO; re.data = 128'h0; re.err = 1'b1; end
    else     begin r = d + 1;      re.data = res;     re.err = 1'b0; end
    re.cyc = r;
    rsp_q.push_back(re);
    @(negedge clk);
    if (w) req1_valid = 1'b0; else req0_valid = 1'b0;
    while (cyc < r) begin
      if (spur && cyc == t + 3) begin core_done = 1'b1; core_result = rand128(); end
      else if (!tmo && cyc == d) begin core_done = 1'b1; core_result = res; end
      else begin core_done = 1'b0; core_result = rand128(); end
      @(negedge clk);
    end
    core_done = 1'b0;
    for (int i = 0; i < bp; i++) begin
      if (w) rsp0_ready = 1'($urandom_range(0, 1)); else rsp1_ready = 1'($urandom_range(0, 1));
      core_done = late && (i == 1);
      core_result = rand128();
      @(negedge clk);
    end
    core_done = 1'b0;
    if (w) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    model_last = w;
    chk("ready_pulses", ready_pulses, exp_pulses);
  endtask

  initial begin
    int t, n;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    core_done = 1'b0; core_result = 128'h0; t8_req0_valid = 1'b0; t8_rsp0_ready = 1'b0;
    rand_keys();
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, buf_ld, buf_key, buf_text, rsp0_valid, rsp1_valid, rsp_err, req0_ready, req1_ready}, 0);
    chk("reset_rsp_data", rsp_data, 0);
    rst = 1'b0;

    // Contention from reset: model expects 0,1,0,1
    for (int j = 0; j < 4; j++) begin
      rand_keys();
      run_job(2'b11, 0, 1'b0, j, 1'b0, j, 1'b0, rand128());
    end

    // Known-answer single job, done at T+8
    req0_key  = 128'h000102030405060708090a0b0c0d0e0f;
    req0_text = 128'h00112233445566778899aabbccddeeff;
    run_job(2'b01, 1, 1'b0, 3, 1'b0, 0, 1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    // Timeout, and done on the final timeout cycle
    rand_keys();
    run_job(2'b01, 0, 1'b1, 0, 1'b0, 2, 1'b1, 128'h0);
    run_job(2'b10, 0, 1'b0, TO - 1, 1'b0, 0, 1'b0, rand128());

    // Backpressure with requester 1 waiting, then spurious done in LOAD
    rand_keys();
    run_job(2'b11, 0, 1'b0, 4, 1'b0, 10, 1'b1, rand128());
    run_job(2'b11, 0, 1'b0, 2, 1'b1, 0, 1'b0, rand128());

    // Reset during WAIT: job dropped, round-robin restarts at requester 0
    rand_keys();
    req0_valid = 1'b1;
    #1;
    chk("rst_test_grant", req0_ready, 1);
    exp_pulses++;
    beat_q.push_back('{cyc + 1, req0_key, req0_text});
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
    chk("post_rst_outputs", {busy, buf_ld, buf_key, buf_text, rsp0_valid, rsp1_valid, rsp_err}, 0);
    chk("post_rst_data", rsp_data, 0);
    core_done = 1'b1; core_result = rand128();
    @(negedge clk);
    core_done = 1'b0;
    repeat (10) @(negedge clk);
    rand_keys();
    run_job(2'b11, 0, 1'b0, 1, 1'b0, 1, 1'b0, rand128());

    // Randomized jobs
    for (int j = 0; j < 20; j++) begin
      rand_keys();
      run_job(2'($urandom_range(1, 3)), $urandom_range(0, 2), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO - 1) : $urandom_range(0, 6),
              1'($urandom_range(0, 1)), $urandom_range(0, 5), 1'($urandom_range(0, 1)), rand128());
    end
    repeat (3) @(negedge clk);
    chk("rsp_q_drained", rsp_q.size(), 0);
    chk("beat_q_drained", beat_q.size(), 0);

    // Short timeout instance
    t8_req0_valid = 1'b1;
    #1;
    chk("t8_ready", t8_req0_ready, 1);
    t = cyc;
    @(negedge clk);
    t8_req0_valid = 1'b0;
    n = 0;
    while (!t8_rsp0_valid && n < 40) begin @(negedge clk); n++; end
    chk("t8_rsp_cycle", cyc, t + 5 + TO8);
    chk("t8_rsp_err", t8_rsp_err, 1);
    chk("t8_rsp_data", t8_rsp_data, 0);
    t8_rsp0_ready = 1'b1;
    @(negedge clk);
    t8_rsp0_ready = 1'b0;
    chk("t8_rsp_clear", {t8_rsp0_valid, t8_rsp1_valid, t8_rsp_err, t8_busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_job_arbiter.md
Name: aes_job_arbiter

Overview:
Shares one AES input buffer and core between two requesters. Each requester submits a full 128-bit key/text job via valid/ready. The arbiter grants requesters round-robin and serialises the granted job into four 32-bit beats for the input buffer. It then waits for the core's done pulse, with a timeout, and returns the 128-bit result to the granted requester through a valid/ready response port.

Parameters:
WORD_W, 32, beat width toward the input buffer; NUM_BEATS = 128/WORD_W = 4.
TIMEOUT_CYCLES, 64, maximum WAIT cycles before an error response; counter width is clog2(TIMEOUT_CYCLES).

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 job valid
req0_ready  out  1  one-cycle accept pulse for requester 0
req0_key  in  128  requester 0 key
req0_text  in  128  requester 0 plaintext
req1_valid / req1_ready / req1_key / req1_text  same as requester 0, for requester 1
buf_ld  out  1  high on beat 0 only
buf_key  out  WORD_W  key beat
buf_text  out  WORD_W  text beat
core_done  in  1  core result-valid pulse
core_result  in  128  core output, sampled on core_done
rsp0_valid  out  1  response valid to requester 0
rsp1_valid  out  1  response valid to requester 1
rsp0_ready / rsp1_ready  in  1  response accept
rsp_data  out  128  shared response data
rsp_err  out  1  response is a timeout error
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE; beat counter and timeout counter = 0; last_grant=1, so requester 0 wins first.
  - All outputs 0.
  - Any job in flight is dropped with no response; latched job registers are cleared.
- FSM states: IDLE, LOAD, WAIT, RESP.
- IDLE:
  - Only req0 valid: grant 0. Only req1 valid: grant 1.
  - Both valid: grant the requester not equal to last_grant.
  - On grant: reqN_ready=1 for exactly that cycle; latch key/text into 128-bit job registers; record the grant; go to LOAD with beat=0.
  - reqN_ready is never high outside IDLE and never high for both requesters.
- LOAD, 4 consecutive cycles, beat 0..3:
  - buf_key = job_key[beat*32 +: 32] and buf_text = job_text[beat*32 +: 32]; word 0 ([31:0]) goes first.
  - buf_ld=1 only when beat=0.
  - After beat 3, go to WAIT with timeout counter=0.
  - buf_key/buf_text are 0 outside LOAD.
  - core_done during LOAD is ignored.
- WAIT:
  - Counter increments each cycle.
  - If core_done=1: capture core_result into rsp_data, rsp_err=0, go to RESP.
  - Else if counter == TIMEOUT_CYCLES-1: rsp_data=0, rsp_err=1, go to RESP.
  - core_done on the timeout cycle takes priority (success).
- RESP:
  - rspN_valid=1 for the granted requester only.
  - rsp_data and rsp_err are held stable until rspN_ready=1.
  - On handshake: last_grant=granted, clear rsp_valid and rsp_err, go to IDLE.
  - The ready of the non-granted requester is ignored. core_done in RESP is ignored.
- Latency:
  - Accept at cycle T; beats at T+1..T+4; WAIT starts at T+5.
  - core_done at cycle D gives rspN_valid at D+1.
  - After the response handshake, the next grant is available 1 cycle later (IDLE).
- A requester that drops valid before its grant is simply not granted; no state is kept for it.

Decomposition:
- Shared package aes_pkg:
  - state enum (IDLE, LOAD, WAIT, RESP);
  - AES_BLK_W=128 and AES_WORD_W=32;
  - beat-index typedef.
- Natural sub-module aes_rr_arb2: 2-way round-robin arbiter (req[1:0], last_grant in, grant one-hot out), purely combinational. The main FSM owns the last_grant register.

Test Plan:
- Single job: req0 with key=000102..0F, text=00112233..FF; core_done at T+8 with result=69C4E0D8..C55A.
  - req0_ready pulses at T.
  - buf_ld=1 at T+1 with buf_key=0x0C0D0E0F (word [31:0]).
  - Beats 1..3 on T+2..T+4.
  - rsp0_valid at T+9 with that result, rsp_err=0.
- Contention: req0 and req1 both valid from reset.
  - Grant order is 0, 1, 0, 1 over four jobs.
  - rsp1_valid is never asserted during a requester 0 job.
- Timeout: no core_done after LOAD.
  - rsp_err=1 and rsp_data=0 exactly TIMEOUT_CYCLES cycles after WAIT entry.
  - Same behaviour with TIMEOUT_CYCLES=8.
- Backpressure: rsp0_ready held low for 10 cycles.
  - rsp0_valid and rsp_data stable for 10 cycles.
  - req1_ready stays 0 throughout.
  - Grant to req1 on the cycle after the handshake.
- Reset mid-WAIT: rst=1 for 1 cycle.
  - Next cycle: busy=0 and all outputs 0.
  - A core_done arriving afterwards produces no response.
  - The next simultaneous request grants requester 0.
- Spurious core_done during LOAD beat 2: ignored; the actual done at T+7 is returned correctly.
